// File: rtl/branch_resolve.sv
// Branch resolution at the ID/EX boundary: turns a {gt,eq,lt} compare code and a
// branch op into a registered taken/target result, with a one-cycle fetch redirect.
module branch_resolve #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic [2:0]       cmp,
  input  logic [PC_W-1:0]  pc,
  input  logic [15:0]      imm,
  input  logic             flush_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [PC_W-1:0]  target,
  output logic             redirect,
  output logic             err,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BGTZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BGEZ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // The comparator is expected to drive exactly one of gt/eq/lt.
  function automatic logic cmp_legal(input logic [2:0] c);
    logic ok;
    case (c)
      3'b001:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b100:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic decide(input logic [2:0] op, input logic [2:0] c);
    logic t;
    if (!cmp_legal(c)) begin
      t = 1'b0;
    end else begin
      case (op)
        OP_BEQ:  t = c[1];
        OP_BNE:  t = !c[1];
        OP_BLEZ: t = !c[2];
        OP_BGTZ: t = c[2];
        OP_BLTZ: t = c[0];
        OP_BGEZ: t = !c[0];
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  state_e            state_q, state_d;
  logic              taken_q, taken_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              presented_q, presented_d;
  logic              redirect_q, redirect_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              handoff_s;
  logic              dec_taken_s;
  logic              dec_err_s;
  logic [PC_W-1:0]   imm_ext_s;
  logic [PC_W-1:0]   target_calc_s;

  assign in_ready_s    = !flush_in && ((state_q == EMPTY) || out_ready);
  assign imm_ext_s     = {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign target_calc_s = pc + {{(PC_W-3){1'b0}}, 3'b100} + imm_ext_s;

  // Next-state logic: flush beats accept, accept beats handoff, otherwise hold.
  always_comb begin
    accept_s    = in_valid && in_ready_s;
    handoff_s   = (state_q == FULL) && out_ready && !flush_in;
    dec_taken_s = decide(br_op, cmp);
    dec_err_s   = (br_op == OP_RSVD) || ((br_op != OP_NONE) && !cmp_legal(cmp));

    state_d     = state_q;
    taken_d     = taken_q;
    target_d    = target_q;
    presented_d = presented_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    redirect_d  = 1'b0;

    if (flush_in) begin
      state_d     = EMPTY;
      presented_d = 1'b0;
    end else if (accept_s) begin
      state_d     = FULL;
      taken_d     = dec_taken_s;
      target_d    = target_calc_s;
      presented_d = 1'b0;
    end else if (handoff_s) begin
      state_d     = EMPTY;
      presented_d = 1'b0;
    end else begin
      // A result still held next cycle has already been shown once.
      presented_d = (state_q == FULL);
    end

    if ((state_d == FULL) && taken_d && !presented_d) begin
      redirect_d = 1'b1;
    end else begin
      redirect_d = 1'b0;
    end

    if (accept_s && dec_err_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (handoff_s && taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      taken_q     <= 1'b0;
      target_q    <= {PC_W{1'b0}};
      presented_q <= 1'b0;
      redirect_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      presented_q <= presented_d;
      redirect_q  <= redirect_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == FULL);
  assign taken     = taken_q;
  assign target    = target_q;
  assign redirect  = redirect_q;
  assign err       = err_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a vector table streamed back-to-back plus
// hand-written stall, flush, saturation and asynchronous-reset sequences.
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_op;
  logic [2:0]  cmp;
  logic [31:0] pc;
  logic [15:0] imm;
  logic        flush_in;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target;
  logic        redirect;
  logic        err;
  logic [3:0]  taken_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  branch_resolve #(.PC_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .cmp(cmp), .pc(pc), .imm(imm), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .redirect(redirect), .err(err), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  cm;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        tk;
    logic [31:0] tgt;
    logic        er;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] cm,
                       input logic [31:0] p, input logic [15:0] im);
    in_valid = 1'b1;
    br_op    = op;
    cmp      = cm;
    pc       = p;
    imm      = im;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_taken"},     {31'd0, taken},     32'd0);
    chk({tag, "_target"},    target,             32'd0);
    chk({tag, "_redirect"},  {31'd0, redirect},  32'd0);
    chk({tag, "_err"},       {31'd0, err},       32'd0);
    chk({tag, "_cnt"},       {28'd0, taken_cnt}, 32'd0);
  endtask

  initial begin
    //           op      cmp     pc            imm       tk    target        err
    tbl[0]  = '{3'b001, 3'b010, 32'h00400010, 16'h0003, 1'b1, 32'h00400020, 1'b0};
    tbl[1]  = '{3'b110, 3'b001, 32'h00001000, 16'h0010, 1'b0, 32'h00001044, 1'b0};
    tbl[2]  = '{3'b101, 3'b001, 32'h00000000, 16'hFFFF, 1'b1, 32'h00000000, 1'b0};
    tbl[3]  = '{3'b010, 3'b010, 32'h00000100, 16'h0000, 1'b0, 32'h00000104, 1'b0};
    tbl[4]  = '{3'b011, 3'b100, 32'h00000200, 16'h8000, 1'b0, 32'hFFFE0204, 1'b0};
    tbl[5]  = '{3'b100, 3'b100, 32'hFFFFFFFC, 16'h0000, 1'b1, 32'h00000000, 1'b0};
    tbl[6]  = '{3'b011, 3'b001, 32'h00000010, 16'h0001, 1'b1, 32'h00000018, 1'b0};
    tbl[7]  = '{3'b000, 3'b010, 32'h00000020, 16'h0002, 1'b0, 32'h0000002C, 1'b0};
    tbl[8]  = '{3'b000, 3'b000, 32'h00000000, 16'h0000, 1'b0, 32'h00000004, 1'b0};
    tbl[9]  = '{3'b010, 3'b110, 32'h00000040, 16'h0001, 1'b0, 32'h00000048, 1'b1};
    tbl[10] = '{3'b001, 3'b010, 32'h00000050, 16'h0000, 1'b1, 32'h00000054, 1'b1};
    tbl[11] = '{3'b111, 3'b010, 32'h00000060, 16'h0000, 1'b0, 32'h00000064, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; br_op = 3'b000; cmp = 3'b000;
    pc = 32'd0; imm = 16'd0; flush_in = 1'b0; out_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream with out_ready held high: one result per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].cm, tbl[i].pc, tbl[i].imm);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      if (i > 0 && tbl[i-1].tk) exp_cnt++;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_taken", i),     {31'd0, taken},     {31'd0, tbl[i].tk});
      chk($sformatf("v%0d_target", i),    target,             tbl[i].tgt);
      chk($sformatf("v%0d_redirect", i),  {31'd0, redirect},  {31'd0, tbl[i].tk});
      chk($sformatf("v%0d_err", i),       {31'd0, err},       {31'd0, tbl[i].er});
      chk($sformatf("v%0d_cnt", i),       {28'd0, taken_cnt}, exp_cnt);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_redirect",  {31'd0, redirect},  32'd0);
    chk("drain_cnt",       {28'd0, taken_cnt}, 32'd5);
    exp_cnt = 5;

    // Stall: bgtz taken held for four cycles, redirect only once.
    out_ready = 1'b0;
    drive(3'b100, 3'b100, 32'h00000300, 16'h0004);
    step();
    in_valid = 1'b0;
    chk("stall_redirect0", {31'd0, redirect}, 32'd1);
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      step();
      chk($sformatf("stall%0d_valid", c),    {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_taken", c),    {31'd0, taken},     32'd1);
      chk($sformatf("stall%0d_target", c),   target,             32'h00000314);
      chk($sformatf("stall%0d_redirect", c), {31'd0, redirect},  32'd0);
      chk($sformatf("stall%0d_cnt", c),      {28'd0, taken_cnt}, exp_cnt);
    end
    out_ready = 1'b1;
    step();
    exp_cnt++;
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_release_cnt",   {28'd0, taken_cnt}, exp_cnt);

    // Flush with a simultaneous request while a taken result is pending.
    out_ready = 1'b0;
    drive(3'b100, 3'b100, 32'h00000400, 16'h0000);
    step();
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    drive(3'b001, 3'b010, 32'h00000500, 16'h0000);
    flush_in = 1'b1;
    out_ready = 1'b1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush_in = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid",    {31'd0, out_valid}, 32'd0);
    chk("flush_redirect", {31'd0, redirect},  32'd0);
    chk("flush_cnt",      {28'd0, taken_cnt}, exp_cnt);
    step();
    chk("flush_not_accepted", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt_after",    {28'd0, taken_cnt}, exp_cnt);

    // Saturation of the 4-bit counter.
    for (int k = 0; k < 12; k++) begin
      drive(3'b001, 3'b010, 32'h00001000, 16'h0000);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_cnt", {28'd0, taken_cnt}, 32'h0000000F);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(3'b100, 3'b100, 32'h00002000, 16'h0001);
    step();
    in_valid = 1'b0;
    chk("areset_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("areset");
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("areset_in_ready", {31'd0, in_ready}, 32'd1);

    // Reserved op with a legal compare code sets err on its own.
    drive(3'b111, 3'b001, 32'h00000000, 16'h0000);
    step();
    in_valid = 1'b0;
    chk("rsvd_err",   {31'd0, err},   32'd1);
    chk("rsvd_taken", {31'd0, taken}, 32'd0);
    step();
    chk("rsvd_err_sticky", {31'd0, err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer of the 3-bit signed compare code {gt, eq, lt} produced by the 32-bit comparator.
- Sits at the ID/EX boundary of the MIPS pipeline.
- Accepts a branch op, the compare code, the PC and a 16-bit offset over a valid/ready handshake.
- Registers the taken/not-taken decision and the target address, and raises a one-cycle redirect pulse for the fetch stage.

Parameters:
- PC_W, 32, width of PC and target.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- br_op  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved.
- cmp  in  3  [2] A>B signed, [1] A==B, [0] A<B; B is 0 for the single-operand ops.
- pc  in  PC_W  address of the branch instruction.
- imm  in  16  branch offset in words.
- flush_in  in  1  kill from a later stage.
- out_valid  out  1  result register holds a valid decision.
- out_ready  in  1  downstream accepts the result.
- taken  out  1  registered decision.
- target  out  PC_W  registered branch target.
- redirect  out  1  one-cycle pulse, asserted in the cycle a taken result is first presented.
- err  out  1  sticky: illegal cmp code or reserved op seen.
- taken_cnt  out  CNT_W  count of taken results handed off.

Behaviour:
- Reset (async, rst_n=0) clears all outputs: out_valid=0, taken=0, target=0, redirect=0, err=0, taken_cnt=0. After rst_n rises, in_ready=1 in the first cycle.
- in_ready = !flush_in && (!out_valid || out_ready). Combinational, single-entry pipeline register.
- Accept happens when in_valid && in_ready. The result loads at that clock edge and out_valid=1 on the next cycle, giving a latency of 1.
- Decision on accept:
  - beq: eq.
  - bne: !eq.
  - blez: gt=0.
  - bgtz: gt.
  - bltz: lt.
  - bgez: lt=0.
  - none/reserved: taken=0.
- cmp legality: cmp must be one-hot. 000, 011, 101, 110 and 111 are illegal.
  - On accept with an illegal cmp and br_op != none: taken=0 and err set.
  - A reserved br_op also sets err.
  - err clears only on reset.
- target = pc + 4 + (sign_extend(imm) << 2), mod 2^PC_W, no overflow flag. target is loaded on every accept, whether taken or not.
- Result hold: taken and target are stable while out_valid && !out_ready.
- Handoff happens when out_valid && out_ready. If no new accept occurs in the same cycle, out_valid falls the next cycle. Back-to-back accept and handoff in the same cycle keeps out_valid=1 and loads the new result.
- redirect = 1 for exactly the first cycle a taken result is valid, and is not repeated while stalled. An internal "presented" flag is required for this.
- taken_cnt increments by 1 on a handoff with taken=1, and saturates at all-ones.
- flush_in (synchronous priority):
  - Next cycle: out_valid=0 and redirect=0.
  - Any result pending in that cycle is dropped and not counted.
  - in_ready=0 during flush_in, so a simultaneous in_valid is not accepted.
  - err and taken_cnt are unaffected.
- Reset mid-operation: the pending result is lost, and all state returns to reset values immediately (asynchronous).
- The FSM is implicit in two states:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on handoff without accept, or on flush.
  - FULL → FULL on handoff with accept, or on stall.

Test Plan:
- beq, cmp=010, pc=0x00400010, imm=0x0003, out_ready=1 → next cycle out_valid=1, taken=1, target=0x00400020, redirect high 1 cycle, taken_cnt=1.
- bgez then bltz back-to-back, cmp=001 both, out_ready=1 → taken 0 then 1, in_ready held 1, no bubble. Also imm=0xFFFF at pc=0x00000000 → target=0x00000000.
- bgtz, cmp=100, out_ready=0 for 4 cycles → taken=1 and target stable, redirect high only in the first cycle, in_ready=0, taken_cnt increments once after out_ready=1.
- bne, cmp=110 (illegal) → taken=0, err=1. err remains 1 after subsequent legal ops. br_op=111 with a legal cmp also sets err.
- Valid taken result with out_ready=0, then flush_in=1 together with in_valid=1 → out_valid=0 next cycle, input not accepted, taken_cnt unchanged.
- Preload taken_cnt near all-ones via repeated taken branches (CNT_W overridden to 4) → counter stops at 0xF. Then assert rst_n=0 mid-stall → all outputs 0 immediately, without waiting for a clock edge.
